// File: rtl/word_clipper_pkg.sv
// Shared constants and helpers for the word segment queue: default widths,
// segment length arithmetic and saturating-counter support.
package word_clipper_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT  = 16;

  // Helpers run at a fixed maximum width; callers zero-extend their operands.
  localparam int unsigned SEG_MAX_W = 64;
  localparam int unsigned CNT_MAX_W = 32;

  // Inclusive length end-start+1, one bit wider than the operands.
  function automatic logic [SEG_MAX_W:0] seg_len(input logic [SEG_MAX_W-1:0] start_addr,
                                                 input logic [SEG_MAX_W-1:0] end_addr);
    return {1'b0, end_addr} - {1'b0, start_addr} + (SEG_MAX_W+1)'(1);
  endfunction

  // True while a counter of the given width is below all-ones.
  function automatic logic cnt_can_inc(input logic [CNT_MAX_W-1:0] cnt,
                                       input int unsigned width);
    logic [CNT_MAX_W-1:0] max_v;
    max_v = (width >= CNT_MAX_W) ? '1 : ((CNT_MAX_W'(1) << width) - CNT_MAX_W'(1));
    return cnt != max_v;
  endfunction

endpackage

// File: rtl/word_segment_queue_if.sv
// Segment ingress strobe plus rts/rtr egress handshake of the word segment queue.
interface word_segment_queue_if
  import word_clipper_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) ();

  logic              ivalid;
  logic [ADDR_W-1:0] istart_addr;
  logic [ADDR_W-1:0] iend_addr;
  logic              orts;
  logic              irtr;
  logic [ADDR_W-1:0] ostart_addr;
  logic [ADDR_W-1:0] oend_addr;

  modport master (
    output ivalid, istart_addr, iend_addr, irtr,
    input  orts, ostart_addr, oend_addr
  );

  modport slave (
    input  ivalid, istart_addr, iend_addr, irtr,
    output orts, ostart_addr, oend_addr
  );

endinterface

// File: rtl/word_seg_fifo_mem.sv
// DEPTH x 2*ADDR_W segment storage: one synchronous write port, one async read port.
module word_seg_fifo_mem #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                  iclk,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [2*ADDR_W-1:0]   wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [2*ADDR_W-1:0]   rdata
);

  logic [2*ADDR_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by the level counter, so stale
  // entries are never presented and resetting the array would only cost flops.
  always_ff @(posedge iclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/word_segment_queue.sv
// Word segment FIFO: filters short/inverted segments, buffers up to DEPTH, presents
// the head on a registered rts/rtr port and counts drops and rejects.
module word_segment_queue
  import word_clipper_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MIN_LEN = 1,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic                   iclk,
  input  logic                   irst,
  word_segment_queue_if.slave    seg,
  input  logic                   iclr_cnt,
  output logic [$clog2(DEPTH):0] olevel,
  output logic                   ofull,
  output logic [CNT_W-1:0]       odrop_cnt,
  output logic [CNT_W-1:0]       orej_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [SEG_MAX_W:0]    len;
  logic                  accept, push, pop, drop, reject;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [LVL_W-1:0]      level_after_pop, level_nxt;
  logic [2*ADDR_W-1:0]   rdata;
  logic                  orts_q;
  logic [ADDR_W-1:0]     start_q, end_q, start_nxt, end_nxt;

  // Operands are zero-extended, so for end>=start the wide length is exact.
  assign len    = seg_len(SEG_MAX_W'(seg.istart_addr), SEG_MAX_W'(seg.iend_addr));
  assign accept = (seg.iend_addr >= seg.istart_addr) && (len >= (SEG_MAX_W+1)'(MIN_LEN));

  assign pop    = orts_q & seg.irtr;
  assign push   = seg.ivalid & accept & (~ofull | pop);
  assign drop   = seg.ivalid & accept & ofull & ~pop;
  assign reject = seg.ivalid & ~accept;

  assign ofull           = (olevel == LVL_W'(DEPTH));
  assign level_after_pop = olevel - LVL_W'(pop);
  assign level_nxt       = level_after_pop + LVL_W'(push);
  assign rd_ptr_nxt      = rd_ptr + PTR_W'(pop);

  word_seg_fifo_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .iclk  (iclk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({seg.iend_addr, seg.istart_addr}),
    .raddr (rd_ptr_nxt),
    .rdata (rdata)
  );

  // Next head: bypass the incoming segment when it lands in an otherwise empty
  // queue, else read the entry behind the pop. Empty queue holds the last value.
  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    start_nxt = start_q;
    end_nxt   = end_q;
    if (level_after_pop == '0) begin
      if (push) begin
        start_nxt = seg.istart_addr;
        end_nxt   = seg.iend_addr;
      end
    end else begin
      start_nxt = rdata[ADDR_W-1:0];
      end_nxt   = rdata[2*ADDR_W-1:ADDR_W];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      olevel  <= '0;
      orts_q  <= 1'b0;
      start_q <= '0;
      end_q   <= '0;
    end else begin
      rd_ptr  <= rd_ptr_nxt;
      wr_ptr  <= wr_ptr + PTR_W'(push);
      olevel  <= level_nxt;
      orts_q  <= (level_nxt != '0);
      start_q <= start_nxt;
      end_q   <= end_nxt;
    end
  end

  // Clear has priority over a coincident drop or reject.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      odrop_cnt <= '0;
      orej_cnt  <= '0;
    end else if (iclr_cnt) begin
      odrop_cnt <= '0;
      orej_cnt  <= '0;
    end else begin
      if (drop && cnt_can_inc(CNT_MAX_W'(odrop_cnt), CNT_W))
        odrop_cnt <= odrop_cnt + CNT_W'(1);
      if (reject && cnt_can_inc(CNT_MAX_W'(orej_cnt), CNT_W))
        orej_cnt <= orej_cnt + CNT_W'(1);
    end
  end

  assign seg.orts        = orts_q;
  assign seg.ostart_addr = start_q;
  assign seg.oend_addr   = end_q;

endmodule

// File: tb/tb_word_segment_queue.sv
// Self-checking bench for word_segment_queue (DEPTH=4, MIN_LEN=50) with a queue scoreboard.
module tb_word_segment_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MIN_LEN = 50;

  logic        iclk = 1'b0;
  logic        irst;
  logic        iclr_cnt;
  logic [2:0]  olevel;
  logic        ofull;
  logic [15:0] odrop_cnt;
  logic [15:0] orej_cnt;

  word_segment_queue_if #(.ADDR_W(32)) sif ();

  word_segment_queue #(
    .ADDR_W  (32),
    .DEPTH   (DEPTH),
    .MIN_LEN (MIN_LEN),
    .CNT_W   (16)
  ) dut (
    .iclk      (iclk),
    .irst      (irst),
    .seg       (sif),
    .iclr_cnt  (iclr_cnt),
    .olevel    (olevel),
    .ofull     (ofull),
    .odrop_cnt (odrop_cnt),
    .orej_cnt  (orej_cnt)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
  } seg_t;

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    logic [15:0] exp_rej;
    logic [2:0]  exp_level;
  } vec_t;

  seg_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [15:0] m_drop = '0;
  logic [15:0] m_rej  = '0;
  logic [31:0] last_s = '0;
  logic [31:0] last_e = '0;
  vec_t        vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic post_check();
    if (q.size() != 0) begin
      last_s = q[0].s;
      last_e = q[0].e;
    end
    check("level", 64'(olevel), 64'(q.size()));
    check("orts", 64'(sif.orts), 64'(q.size() != 0));
    check("full", 64'(ofull), 64'(q.size() == DEPTH));
    check("head_start", 64'(sif.ostart_addr), 64'(last_s));
    check("head_end", 64'(sif.oend_addr), 64'(last_e));
    check("drop_cnt", 64'(odrop_cnt), 64'(m_drop));
    check("rej_cnt", 64'(orej_cnt), 64'(m_rej));
  endtask

  // One clock: drive inputs, update the scoreboard, sample #1 after the edge.
  task automatic step(input logic v, input logic [31:0] s, input logic [31:0] e,
                      input logic rtr, input logic clr);
    logic acc, pop_m;
    int   sz;
    seg_t tmp;
    sif.ivalid      = v;
    sif.istart_addr = s;
    sif.iend_addr   = e;
    sif.irtr        = rtr;
    iclr_cnt        = clr;
    sz    = q.size();
    pop_m = (sz != 0) && rtr;
    acc   = (e >= s) && (({1'b0, e} - {1'b0, s} + 33'd1) >= 33'(MIN_LEN));
    if (pop_m) begin
      tmp = q.pop_front();
      pops++;
    end
    if (v && !acc) begin
      if (m_rej != 16'hFFFF) m_rej++;
    end else if (v) begin
      if (sz < DEPTH || pop_m) q.push_back('{s, e});
      else if (m_drop != 16'hFFFF) m_drop++;
    end
    if (clr) begin
      m_drop = '0;
      m_rej  = '0;
    end
    @(posedge iclk);
    #1;
    sif.ivalid = 1'b0;
    iclr_cnt   = 1'b0;
    post_check();
  endtask

  initial begin
    logic [15:0] drop_before;
    irst            = 1'b1;
    iclr_cnt        = 1'b0;
    sif.ivalid      = 1'b0;
    sif.istart_addr = '0;
    sif.iend_addr   = '0;
    sif.irtr        = 1'b0;
    #3;
    post_check();
    @(negedge iclk);
    irst = 1'b0;
    @(posedge iclk);
    #1;

    // Single segment, then pop; head value holds once empty
    step(1'b1, 32'd100, 32'd199, 1'b0, 1'b0);
    check("t1_orts", 64'(sif.orts), 64'd1);
    check("t1_start", 64'(sif.ostart_addr), 64'd100);
    check("t1_end", 64'(sif.oend_addr), 64'd199);
    check("t1_level", 64'(olevel), 64'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("t1_pop_orts", 64'(sif.orts), 64'd0);
    check("t1_hold_start", 64'(sif.ostart_addr), 64'd100);

    // Filter vectors with irtr=0
    vecs[0] = '{32'd10, 32'd58, 16'd1, 3'd0};
    vecs[1] = '{32'd10, 32'd59, 16'd1, 3'd1};
    vecs[2] = '{32'd300, 32'd200, 16'd2, 3'd1};
    vecs[3] = '{32'd5, 32'd5, 16'd3, 3'd1};
    vecs[4] = '{32'd0, 32'd49, 16'd3, 3'd2};
    vecs[5] = '{32'hFFFF_FFB0, 32'hFFFF_FFFF, 16'd3, 3'd3};
    vecs[6] = '{32'hFFFF_FFFF, 32'd0, 16'd4, 3'd3};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vecs[i].s, vecs[i].e, 1'b0, 1'b0);
      check($sformatf("vec%0d_rej", i), 64'(orej_cnt), 64'(vecs[i].exp_rej));
      check($sformatf("vec%0d_level", i), 64'(olevel), 64'(vecs[i].exp_level));
    end
    repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Overfill: 6 pushes into DEPTH=4, then pop in order
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'd1000 + 32'(i * 100), 32'd1060 + 32'(i * 100), 1'b0, 1'b0);
    check("fill_level", 64'(olevel), 64'd4);
    check("fill_full", 64'(ofull), 64'd1);
    check("fill_drop", 64'(odrop_cnt), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check("fill_order", 64'(sif.ostart_addr), 64'(1000 + i * 100));
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    end

    // Full with simultaneous push and pop, repeated for pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++)
        step(1'b1, 32'd2000 + 32'(r * 1000 + i * 10), 32'd2100 + 32'(r * 1000 + i * 10), 1'b0, 1'b0);
      drop_before = odrop_cnt;
      step(1'b1, 32'd9000 + 32'(r), 32'd9100 + 32'(r), 1'b1, 1'b0);
      check("fullpp_level", 64'(olevel), 64'd4);
      check("fullpp_drop", 64'(odrop_cnt), 64'(drop_before));
      repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      check("fullpp_last", 64'(sif.ostart_addr), 64'(9000 + r));
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    end

    // Streaming: one segment per cycle with irtr held high
    pops        = 0;
    drop_before = odrop_cnt;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'd5000 + 32'(i * 64), 32'd5063 + 32'(i * 64), 1'b1, 1'b0);
      check("stream_level", 64'(olevel <= 3'd1), 64'd1);
    end
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("stream_pops", 64'(pops), 64'd20);
    check("stream_drop", 64'(odrop_cnt), 64'(drop_before));

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'd700 + 32'(i * 100), 32'd760 + 32'(i * 100), 1'b0, 1'b0);
    #2;
    irst = 1'b1;
    #1;
    q.delete();
    m_drop = '0;
    m_rej  = '0;
    last_s = '0;
    last_e = '0;
    post_check();
    check("rst_async_start", 64'(sif.ostart_addr), 64'd0);
    @(negedge iclk);
    irst = 1'b0;
    @(posedge iclk);
    #1;
    step(1'b1, 32'd20, 32'd90, 1'b0, 1'b0);
    check("rst_after_start", 64'(sif.ostart_addr), 64'd20);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Counter clear coinciding with a drop and with a reject
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'd100 + 32'(i * 100), 32'd160 + 32'(i * 100), 1'b0, 1'b0);
    check("clr_pre_drop", 64'(odrop_cnt), 64'd1);
    step(1'b1, 32'd900, 32'd960, 1'b0, 1'b1);
    check("clr_drop", 64'(odrop_cnt), 64'd0);
    step(1'b1, 32'd50, 32'd60, 1'b0, 1'b0);
    check("clr_pre_rej", 64'(orej_cnt), 64'd1);
    step(1'b1, 32'd50, 32'd60, 1'b0, 1'b1);
    check("clr_rej", 64'(orej_cnt), 64'd0);
    repeat (4) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
